// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package hazard_ctrl_pkg;

  localparam int DEF_NREGS     = 32;
  localparam int DEF_REGNOBITS = 5;
  localparam int DEF_CNTW      = 2;
  localparam int DEF_PERFW     = 32;

  // Control bundle widths: FE gets {stall}, DE gets {bubble, stall}.
  localparam int FROM_HC_TO_FE_WIDTH = 1;
  localparam int FROM_HC_TO_DE_WIDTH = 2;

  typedef enum logic {
    HC_RUN  = 1'b0,
    HC_HALT = 1'b1
  } hc_state_e;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// rtl/hazard_ctrl_scoreboard.sv - per-register pending-write counters with two read ports
module reg_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTW      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic [REGNOBITS-1:0] inc_idx_i,
  input  logic                 dec_i,
  input  logic [REGNOBITS-1:0] dec_idx_i,
  input  logic [REGNOBITS-1:0] rd1_idx_i,
  input  logic [REGNOBITS-1:0] rd2_idx_i,
  output logic                 pend1_o,
  output logic                 pend2_o,
  output logic                 underflow_o
);

  logic [CNTW-1:0] cnt_q [NREGS];
  logic [CNTW-1:0] cnt_d [NREGS];

  // A matching inc and dec on one register cancel; x0 is pinned to zero.
  always_comb begin
    underflow_o = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_i && (inc_idx_i == REGNOBITS'(r)) &&
                   !(dec_i && (dec_idx_i == REGNOBITS'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNTW'(1);
      end else if (dec_i && (dec_idx_i == REGNOBITS'(r)) &&
                   !(inc_i && (inc_idx_i == REGNOBITS'(r)))) begin
        if (cnt_q[r] == '0) begin
          underflow_o = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign pend1_o = (cnt_q[rd1_idx_i] != '0);
  assign pend2_o = (cnt_q[rd2_idx_i] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW stall, branch flush and halt control for the five-stage core
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREGS     = DEF_NREGS,
  parameter int REGNOBITS = DEF_REGNOBITS,
  parameter int CNTW      = DEF_CNTW,
  parameter int PERFW     = DEF_PERFW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 agex_valid,
  input  logic                 agex_br_taken,
  input  logic                 wb_valid,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_rd,
  input  logic                 wb_halt,
  output logic                 stall_fe,
  output logic                 stall_de,
  output logic                 bubble_de,
  output logic                 bubble_agex,
  output logic                 de_issue,
  output logic                 halted,
  output logic                 err_underflow,
  output logic [PERFW-1:0]     stall_cnt,
  output logic [PERFW-1:0]     flush_cnt
);

  hc_state_e state_q, state_d;
  logic [PERFW-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERFW-1:0] flush_cnt_q, flush_cnt_d;
  logic err_q, err_d;

  logic [FROM_HC_TO_FE_WIDTH-1:0] fe_ctrl;
  logic [FROM_HC_TO_DE_WIDTH-1:0] de_ctrl;
  logic agex_bubble, issue, halt_flag;

  logic pend1, pend2, underflow, raw, flush, sb_inc, sb_dec;

  assign sb_inc = issue & de_wr_reg & (de_rd != '0);
  assign sb_dec = wb_valid & wb_wr_reg & (wb_rd != '0);

  reg_scoreboard #(
    .NREGS     (NREGS),
    .REGNOBITS (REGNOBITS),
    .CNTW      (CNTW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (reset),
    .inc_i       (sb_inc),
    .inc_idx_i   (de_rd),
    .dec_i       (sb_dec),
    .dec_idx_i   (wb_rd),
    .rd1_idx_i   (de_rs1),
    .rd2_idx_i   (de_rs2),
    .pend1_o     (pend1),
    .pend2_o     (pend2),
    .underflow_o (underflow)
  );

  // Pre-edge counts: a same-cycle retire has not reached the register file yet.
  assign raw   = de_valid & ((de_rs1_used & pend1) | (de_rs2_used & pend2));
  assign flush = agex_valid & agex_br_taken;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q | underflow;
    fe_ctrl     = '0;
    de_ctrl     = '0;
    agex_bubble = 1'b0;
    issue       = 1'b0;
    halt_flag   = 1'b0;
    if (!reset) begin
      err_d = err_q;
    end else if (state_q == HC_HALT) begin
      fe_ctrl     = 1'b1;
      de_ctrl     = 2'b10;
      agex_bubble = 1'b1;
      halt_flag   = 1'b1;
    end else begin
      if (wb_valid && wb_halt) begin
        state_d = HC_HALT;
      end
      if (flush) begin
        de_ctrl     = 2'b10;
        agex_bubble = 1'b1;
        flush_cnt_d = flush_cnt_q + PERFW'(1);
      end else if (raw) begin
        fe_ctrl     = 1'b1;
        de_ctrl     = 2'b01;
        agex_bubble = 1'b1;
        stall_cnt_d = stall_cnt_q + PERFW'(1);
      end else begin
        issue = de_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HC_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_fe      = fe_ctrl[0];
  assign stall_de      = de_ctrl[0];
  assign bubble_de     = de_ctrl[1];
  assign bubble_agex   = agex_bubble;
  assign de_issue      = issue;
  assign halted        = halt_flag;
  assign err_underflow = err_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_rs1_used, de_rs2_used, de_wr_reg;
  logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
  logic        agex_valid, agex_br_taken;
  logic        wb_valid, wb_wr_reg, wb_halt;
  logic        stall_fe, stall_de, bubble_de, bubble_agex, de_issue, halted, err_underflow;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .de_valid      (de_valid),
    .de_rs1        (de_rs1),
    .de_rs2        (de_rs2),
    .de_rs1_used   (de_rs1_used),
    .de_rs2_used   (de_rs2_used),
    .de_wr_reg     (de_wr_reg),
    .de_rd         (de_rd),
    .agex_valid    (agex_valid),
    .agex_br_taken (agex_br_taken),
    .wb_valid      (wb_valid),
    .wb_wr_reg     (wb_wr_reg),
    .wb_rd         (wb_rd),
    .wb_halt       (wb_halt),
    .stall_fe      (stall_fe),
    .stall_de      (stall_de),
    .bubble_de     (bubble_de),
    .bubble_agex   (bubble_agex),
    .de_issue      (de_issue),
    .halted        (halted),
    .err_underflow (err_underflow),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
    de_wr_reg = 0; de_rd = 0; agex_valid = 0; agex_br_taken = 0;
    wb_valid = 0; wb_wr_reg = 0; wb_rd = 0; wb_halt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1; wb_wr_reg = 1; wb_rd = r;
  endtask

  // An increment at count 3 cannot happen with a three-deep back end.
  always @(negedge clk) begin
    if (reset === 1'b1 && de_issue === 1'b1 && de_wr_reg === 1'b1 && de_rd != 5'd0) begin
      total++;
      assert (dut.u_sb.cnt_q[de_rd] != 2'd3) else begin
        bad++;
        $error("FAIL inc_at_max observed=%0d expected=<3", dut.u_sb.cnt_q[de_rd]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      {de_valid, de_rs1_used, de_rs2_used, de_wr_reg, agex_valid, agex_br_taken,
       wb_valid, wb_wr_reg, wb_halt} = 9'($urandom);
      de_rs1 = 5'($urandom); de_rs2 = 5'($urandom); de_rd = 5'($urandom); wb_rd = 5'($urandom);
    end
    @(negedge clk);
    chk("rst_stall_fe", stall_fe, 0);
    chk("rst_stall_de", stall_de, 0);
    chk("rst_bubble_de", bubble_de, 0);
    chk("rst_bubble_agex", bubble_agex, 0);
    chk("rst_de_issue", de_issue, 0);
    chk("rst_halted", halted, 0);

    step(); reset = 1'b1; idle();
    de_valid = 1; de_rs1 = 5; de_rs1_used = 1;
    @(negedge clk);
    chk("post_rst_stall", stall_de, 0);
    chk("post_rst_issue", de_issue, 1);
    chk("post_rst_err", err_underflow, 0);
    chk("post_rst_stall_cnt", stall_cnt, 0);

    // RAW on x5: producer issues at cycle 0, retires at cycle 3
    step(); idle(); de_valid = 1; de_wr_reg = 1; de_rd = 5;
    @(negedge clk); chk("raw_c0_issue", de_issue, 1);
    step(); idle(); de_valid = 1; de_rs1 = 5; de_rs1_used = 1; de_wr_reg = 1; de_rd = 6;
    @(negedge clk);
    chk("raw_c1_stall_de", stall_de, 1);
    chk("raw_c1_stall_fe", stall_fe, 1);
    chk("raw_c1_bubble_agex", bubble_agex, 1);
    chk("raw_c1_issue", de_issue, 0);
    step();
    @(negedge clk); chk("raw_c2_stall_de", stall_de, 1);
    step(); retire(5);
    @(negedge clk);
    chk("raw_c3_stall_de", stall_de, 1);
    chk("raw_c3_issue", de_issue, 0);
    step(); wb_valid = 0; wb_wr_reg = 0; wb_rd = 0;
    @(negedge clk);
    chk("raw_c4_issue", de_issue, 1);
    chk("raw_c4_stall_de", stall_de, 0);
    chk("raw_stall_cnt", stall_cnt, 3);
    step(); idle(); retire(6);

    // x0 is never pending
    step(); idle(); de_valid = 1; de_wr_reg = 1; de_rd = 0;
    @(negedge clk); chk("x0_wr_issue", de_issue, 1);
    step(); idle(); de_valid = 1; de_rs1_used = 1; de_rs2_used = 1;
    @(negedge clk);
    chk("x0_rd_stall", stall_de, 0);
    chk("x0_rd_issue", de_issue, 1);
    chk("x0_cnt", 32'(dut.u_sb.cnt_q[0]), 0);

    // flush takes priority over a RAW on x7
    step(); idle(); de_valid = 1; de_wr_reg = 1; de_rd = 7;
    step(); idle(); de_valid = 1; de_rs1 = 7; de_rs1_used = 1; de_wr_reg = 1; de_rd = 8;
    agex_valid = 1; agex_br_taken = 1;
    @(negedge clk);
    chk("fl_bubble_de", bubble_de, 1);
    chk("fl_bubble_agex", bubble_agex, 1);
    chk("fl_stall_fe", stall_fe, 0);
    chk("fl_stall_de", stall_de, 0);
    chk("fl_issue", de_issue, 0);
    step(); idle(); de_valid = 1; de_rs1 = 8; de_rs1_used = 1;
    @(negedge clk);
    chk("fl_x8_not_pending", de_issue, 1);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 3);
    step(); idle(); retire(7);

    // same-cycle inc/dec of x9 at count 1
    step(); idle(); de_valid = 1; de_wr_reg = 1; de_rd = 9;
    step(); idle(); de_valid = 1; de_wr_reg = 1; de_rd = 9; retire(9);
    @(negedge clk); chk("x9_incdec_issue", de_issue, 1);
    step(); idle(); de_valid = 1; de_rs1 = 9; de_rs1_used = 1;
    @(negedge clk); chk("x9_still_pending", stall_de, 1);
    step(); idle(); retire(9);
    step(); idle(); de_valid = 1; de_rs1 = 9; de_rs1_used = 1;
    @(negedge clk);
    chk("x9_drained_issue", de_issue, 1);
    chk("x9_no_err", err_underflow, 0);

    // underflow on x3
    step(); idle(); retire(3);
    @(negedge clk); chk("uf_pre_edge", err_underflow, 0);
    step(); idle();
    @(negedge clk); chk("uf_set", err_underflow, 1);
    step();
    @(negedge clk);
    chk("uf_sticky", err_underflow, 1);
    chk("uf_stall_cnt", stall_cnt, 4);

    // halt with x10 still in flight
    step(); idle(); de_valid = 1; de_wr_reg = 1; de_rd = 10;
    step(); idle(); wb_valid = 1; wb_halt = 1;
    @(negedge clk);
    chk("halt_c0_halted", halted, 0);
    chk("halt_c0_stall_fe", stall_fe, 0);
    step(); idle(); de_valid = 1; agex_valid = 1; agex_br_taken = 1;
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_stall_fe", stall_fe, 1);
    chk("halt_bubble_de", bubble_de, 1);
    chk("halt_bubble_agex", bubble_agex, 1);
    chk("halt_stall_de", stall_de, 0);
    chk("halt_issue", de_issue, 0);
    chk("halt_x10_pending", 32'(dut.u_sb.cnt_q[10]), 1);
    step(); idle(); retire(10);
    @(negedge clk); chk("halt_hold", halted, 1);
    step(); idle();
    @(negedge clk);
    chk("halt_x10_drained", 32'(dut.u_sb.cnt_q[10]), 0);
    chk("halt_flush_cnt", flush_cnt, 1);

    // reset out of HALT
    step(); reset = 1'b0; de_valid = 1; agex_valid = 1; agex_br_taken = 1;
    @(negedge clk);
    chk("hrst_halted", halted, 0);
    chk("hrst_stall_fe", stall_fe, 0);
    chk("hrst_bubble_de", bubble_de, 0);
    step(); reset = 1'b1; idle(); de_valid = 1; de_rs1 = 10; de_rs1_used = 1;
    @(negedge clk);
    chk("hrst_issue", de_issue, 1);
    chk("hrst_halted_after", halted, 0);
    chk("hrst_err", err_underflow, 0);
    chk("hrst_stall_cnt", stall_cnt, 0);
    chk("hrst_flush_cnt", flush_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
